// File: rtl/send_control_block_pkg.sv
// ============================================================================
// Module   : send_control_block_pkg
// Purpose  : Shared types and constants for the Ethernet frame-issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package send_control_block_pkg;

    typedef enum logic [1:0] {
        ST_GAP       = 2'd0,
        ST_PULSE     = 2'd1,
        ST_HOLD      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam int HOLD_CYCLES = 2;

    localparam int SW_MAX_LSB  = 0;
    localparam int SW_MAX_MSB  = 3;
    localparam int SW_COPY_LSB = 4;
    localparam int SW_COPY_MSB = 6;
    localparam int SW_PAUSE    = 7;

endpackage

`default_nettype wire

// File: rtl/send_control_block_max_count_gen.sv
// ============================================================================
// Module   : max_count_gen
// Purpose  : Decodes the 4-bit segment select into the highest segment index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_count_gen (
    input  logic [3:0]  i_sel,
    output logic [15:0] o_max
);

    always_comb begin
        o_max = (16'd1 << i_sel) - 16'd1;
    end

endmodule

`default_nettype wire

// File: rtl/send_control_block.sv
// ============================================================================
// Module   : send_control_block
// Purpose  : Launches frames, enforces the inter-frame gap and advances ids.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module send_control_block
    import send_control_block_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 16
) (
    input  logic        clk125MHz,
    input  logic        rstn,
    input  logic [7:0]  switches,
    input  logic        busy,
    output logic [15:0] segment_num,
    output logic [7:0]  txid_inter,
    output logic [7:0]  aux,
    output logic        start_sending
);

    localparam logic [15:0] C_IFG       = 16'(IFG_CYCLES);
    localparam logic [1:0]  C_HOLD_LAST = 2'(HOLD_CYCLES - 1);

    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    state_t      r_state;
    logic [15:0] r_gap_cnt;
    logic [1:0]  r_hold_cnt;
    logic [15:0] r_seg;
    logic [7:0]  r_copy;
    logic [7:0]  r_aux;
    logic        r_start;

    logic [15:0] w_max;
    logic [7:0]  w_last_copy;
    logic        w_pause;

    max_count_gen u_max_count_gen (
        .i_sel (r_sw_sync[SW_MAX_MSB:SW_MAX_LSB]),
        .o_max (w_max)
    );

    assign w_last_copy = {5'd0, r_sw_sync[SW_COPY_MSB:SW_COPY_LSB]};
    assign w_pause     = r_sw_sync[SW_PAUSE];

    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            r_sw_meta <= 8'd0;
            r_sw_sync <= 8'd0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clk125MHz or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_GAP;
            r_gap_cnt  <= 16'd0;
            r_hold_cnt <= 2'd0;
            r_seg      <= 16'd0;
            r_copy     <= 8'd0;
            r_aux      <= 8'd0;
            r_start    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_GAP: begin
                    if (w_pause) begin
                        r_gap_cnt <= 16'd0;
                    end else if (r_gap_cnt == C_IFG) begin
                        r_gap_cnt <= 16'd0;
                        r_start   <= 1'b1;
                        r_state   <= ST_PULSE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                ST_PULSE: begin
                    r_hold_cnt <= 2'd0;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_hold_cnt == C_HOLD_LAST) begin
                        r_state <= ST_WAIT_DONE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!busy) begin
                        if (r_copy < w_last_copy) begin
                            r_copy <= r_copy + 8'd1;
                        end else begin
                            r_copy <= 8'd0;
                            if (r_seg >= w_max) begin
                                r_seg <= 16'd0;
                                r_aux <= r_aux + 8'd1;
                            end else begin
                                r_seg <= r_seg + 16'd1;
                            end
                        end
                        // The exit edge counts as the first gap cycle, so a
                        // fresh gap (reset, pause release) is one cycle longer.
                        r_gap_cnt <= 16'd1;
                        r_state   <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_GAP;
                end
            endcase
        end
    end

    assign segment_num   = r_seg;
    assign txid_inter    = r_copy;
    assign aux           = r_aux;
    assign start_sending = r_start;

endmodule

`default_nettype wire

// File: tb/tb_send_control_block.sv
// ============================================================================
// Module   : tb_send_control_block
// Purpose  : Scoreboard-driven bench for the frame-issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_send_control_block;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  switches = 8'd0;
    logic        busy = 1'b0;
    logic [15:0] segment_num;
    logic [7:0]  txid_inter;
    logic [7:0]  aux;
    logic        start_sending;

    send_control_block #(.IFG_CYCLES(16)) dut (
        .clk125MHz     (clk),
        .rstn          (rstn),
        .switches      (switches),
        .busy          (busy),
        .segment_num   (segment_num),
        .txid_inter    (txid_inter),
        .aux           (aux),
        .start_sending (start_sending)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] seg;
        logic [7:0]  copy;
        logic [7:0]  aux;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_seg;
    logic [7:0]  m_copy;
    logic [7:0]  m_aux;

    task automatic model_push();
        exp_t e;
        e.seg  = m_seg;
        e.copy = m_copy;
        e.aux  = m_aux;
        exp_q.push_back(e);
    endtask

    task automatic model_advance(input logic [15:0] mx, input int r);
        if (int'(m_copy) < r - 1) begin
            m_copy = m_copy + 8'd1;
        end else begin
            m_copy = 8'd0;
            if (m_seg >= mx) begin
                m_seg = 16'd0;
                m_aux = m_aux + 8'd1;
            end else begin
                m_seg = m_seg + 16'd1;
            end
        end
    endtask

    task automatic apply_reset(input logic [7:0] sw, output int rel);
        @(negedge clk);
        rstn     = 1'b0;
        switches = sw;
        busy     = 1'b0;
        repeat (3) @(negedge clk);
        rstn   = 1'b1;
        rel    = cyc;
        m_seg  = 16'd0;
        m_copy = 8'd0;
        m_aux  = 8'd0;
        exp_q.delete();
    endtask

    // Returns the edge count at which start_sending was seen, or -1.
    task automatic wait_pulse(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (start_sending === 1'b1) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL pulse_timeout: got no start_sending, required one within %0d cycles", budget);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({segment_num, txid_inter, aux, start_sending} !== 33'd0) begin
            bad++;
            $display("FAIL reset_values: got seg=%0d copy=%0d aux=%0d start=%b, required all 0",
                     segment_num, txid_inter, aux, start_sending);
        end
    endtask

    task automatic test_basic();
        int   rel, at, prev;
        exp_t e;
        apply_reset(8'b01011111, rel);
        prev = rel;
        for (int i = 0; i < 187; i++) begin
            model_push();
            wait_pulse(40, at);
            if (at < 0) return;
            e = exp_q.pop_front();
            total++;
            if (at - prev !== ((i == 0) ? 17 : 20)) begin
                bad++;
                $display("FAIL basic_period pulse %0d: got %0d cycles, required %0d",
                         i, at - prev, (i == 0) ? 17 : 20);
            end
            total++;
            if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
                bad++;
                $display("FAIL basic_ids pulse %0d: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                         i, segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
            end
            prev = at;
            model_advance(16'd32767, 6);
        end
        total++;
        if ({segment_num, txid_inter} !== {16'd31, 8'd0}) begin
            bad++;
            $display("FAIL basic_seg31: got seg=%0d copy=%0d, required seg=31 copy=0",
                     segment_num, txid_inter);
        end
    endtask

    task automatic test_wrap();
        int          rel, at;
        exp_t        e;
        logic [15:0] t_seg[5]  = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd0};
        logic [7:0]  t_copy[5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
        logic [7:0]  t_aux[5]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        apply_reset(8'b00010001, rel);
        for (int i = 0; i < 5; i++) begin
            e.seg  = t_seg[i];
            e.copy = t_copy[i];
            e.aux  = t_aux[i];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            wait_pulse(40, at);
            if (at < 0) return;
            e = exp_q.pop_front();
            total++;
            if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
                bad++;
                $display("FAIL wrap_ids step %0d: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                         i, segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
            end
        end
    endtask

    task automatic test_busy();
        int   rel, at, prev;
        exp_t e;
        logic stable;
        apply_reset(8'b00010001, rel);
        prev = rel;
        for (int k = 0; k < 3; k++) begin
            model_push();
            wait_pulse(100, at);
            if (at < 0) return;
            e = exp_q.pop_front();
            total++;
            if (at - prev !== ((k == 0) ? 17 : 70)) begin
                bad++;
                $display("FAIL busy_period frame %0d: got %0d cycles, required %0d",
                         k, at - prev, (k == 0) ? 17 : 70);
            end
            prev   = at;
            stable = 1'b1;
            // WAIT_DONE sees busy high on exactly 50 edges.
            for (int c = 0; c < 53; c++) begin
                if (c == 2) busy = 1'b1;
                if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) stable = 1'b0;
                if (c > 0 && start_sending !== 1'b0) stable = 1'b0;
                @(negedge clk);
            end
            busy = 1'b0;
            total++;
            if (stable !== 1'b1) begin
                bad++;
                $display("FAIL busy_stable frame %0d: got unstable outputs, required seg=%0d copy=%0d aux=%0d held",
                         k, e.seg, e.copy, e.aux);
            end
            model_advance(16'd1, 2);
        end
    endtask

    task automatic test_pause();
        int   rel, at, q, npulse;
        exp_t e;
        apply_reset(8'b01011111, rel);
        model_push();
        wait_pulse(40, at);
        if (at < 0) return;
        e = exp_q.pop_front();
        @(negedge clk);
        switches[7] = 1'b1;
        model_advance(16'd32767, 6);
        npulse = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (start_sending === 1'b1) npulse++;
        end
        total++;
        if (npulse !== 0) begin
            bad++;
            $display("FAIL pause_no_pulse: got %0d pulses, required 0", npulse);
        end
        total++;
        if ({segment_num, txid_inter, aux} !== {m_seg, m_copy, m_aux}) begin
            bad++;
            $display("FAIL pause_frame_done: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                     segment_num, txid_inter, aux, m_seg, m_copy, m_aux);
        end
        switches[7] = 1'b0;
        q = cyc;
        model_push();
        wait_pulse(60, at);
        if (at < 0) return;
        e = exp_q.pop_front();
        // Two synchronizer edges plus IFG_CYCLES+1 from a zeroed gap count.
        total++;
        if (at - q !== 19) begin
            bad++;
            $display("FAIL pause_resume: got %0d cycles, required 19", at - q);
        end
        total++;
        if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
            bad++;
            $display("FAIL pause_ids: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                     segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
        end
    endtask

    task automatic test_reset_mid();
        int   rel, at;
        exp_t e;
        apply_reset(8'b00010001, rel);
        for (int i = 0; i < 4; i++) begin
            model_push();
            wait_pulse(40, at);
            if (at < 0) return;
            e = exp_q.pop_front();
            if (i < 3) model_advance(16'd1, 2);
        end
        total++;
        if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
            bad++;
            $display("FAIL midreset_pre: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                     segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({segment_num, txid_inter, aux, start_sending} !== 33'd0) begin
            bad++;
            $display("FAIL midreset_async: got seg=%0d copy=%0d aux=%0d start=%b, required all 0",
                     segment_num, txid_inter, aux, start_sending);
        end
        repeat (3) @(negedge clk);
        rstn   = 1'b1;
        rel    = cyc;
        m_seg  = 16'd0;
        m_copy = 8'd0;
        m_aux  = 8'd0;
        exp_q.delete();
        model_push();
        wait_pulse(40, at);
        if (at < 0) return;
        e = exp_q.pop_front();
        total++;
        if (at - rel !== 17) begin
            bad++;
            $display("FAIL midreset_restart: got %0d cycles, required 17", at - rel);
        end
        total++;
        if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
            bad++;
            $display("FAIL midreset_ids: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                     segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
        end
    endtask

    task automatic test_max_change();
        int          rel, at;
        exp_t        e;
        logic [15:0] mx;
        apply_reset(8'b00001111, rel);
        mx = 16'd32767;
        for (int i = 0; i < 15; i++) begin
            model_push();
            wait_pulse(40, at);
            if (at < 0) return;
            e = exp_q.pop_front();
            total++;
            if ({segment_num, txid_inter, aux} !== {e.seg, e.copy, e.aux}) begin
                bad++;
                $display("FAIL maxchg_ids pulse %0d: got seg=%0d copy=%0d aux=%0d, required seg=%0d copy=%0d aux=%0d",
                         i, segment_num, txid_inter, aux, e.seg, e.copy, e.aux);
            end
            if (i == 11) begin
                total++;
                if ({segment_num, aux} !== {16'd0, 8'd1}) begin
                    bad++;
                    $display("FAIL maxchg_wrap: got seg=%0d aux=%0d, required seg=0 aux=1",
                             segment_num, aux);
                end
            end
            if (i == 10) begin
                switches = 8'b00000010;
                mx       = 16'd3;
            end
            model_advance(mx, 1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_busy();
        test_pause();
        test_reset_mid();
        test_max_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
